// File: rtl/ceespu_memarbiter_if.sv
// Bundle of cache-side and SDRAM-side signals around the ceespu line arbiter.
// The arbiter uses the slave modport; the caches/SDRAM model use master.
interface ceespu_memarbiter_if #(
   parameter int ADDR_BITS = 25,
   parameter int BURST_LEN = 8
);
   localparam int BEAT_BITS = $clog2(BURST_LEN);

   // cache side
   logic [1:0]           req;
   logic [1:0]           we;
   logic [ADDR_BITS-1:0] addr0;
   logic [ADDR_BITS-1:0] addr1;
   logic [31:0]          wdata0;
   logic [31:0]          wdata1;
   logic [1:0]           grant;
   logic [BEAT_BITS-1:0] beat;
   logic [31:0]          rdata;
   logic [1:0]           rvalid;
   logic [1:0]           wnext;
   logic [1:0]           done;

   // SDRAM controller side
   logic                 sd_cmd;
   logic                 sd_we;
   logic [ADDR_BITS-1:0] sd_addr;
   logic                 sd_cmdack;
   logic [31:0]          sd_wdata;
   logic                 sd_wack;
   logic [31:0]          sd_rdata;
   logic                 sd_rvalid;

   modport slave (
      input  req, we, addr0, addr1, wdata0, wdata1,
      input  sd_cmdack, sd_wack, sd_rdata, sd_rvalid,
      output grant, beat, rdata, rvalid, wnext, done,
      output sd_cmd, sd_we, sd_addr, sd_wdata
   );

   modport master (
      output req, we, addr0, addr1, wdata0, wdata1,
      output sd_cmdack, sd_wack, sd_rdata, sd_rvalid,
      input  grant, beat, rdata, rvalid, wnext, done,
      input  sd_cmd, sd_we, sd_addr, sd_wdata
   );
endinterface

// File: rtl/ceespu_memarbiter.sv
// Round-robin line-transfer arbiter between the two ceespu caches and the SDRAM
// controller: one burst command per granted line, then per-beat stepping.
module ceespu_memarbiter #(
   parameter int ADDR_BITS = 25,
   parameter int BURST_LEN = 8
) (
   input  logic                I_clk,
   input  logic                I_rst,
   ceespu_memarbiter_if.slave  bus,
   output logic [1:0]          dbg_state
);
   localparam int BEAT_BITS = $clog2(BURST_LEN);
   localparam int LOW_BITS  = BEAT_BITS + 2;
   localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BURST_LEN - 1);
   localparam logic [ADDR_BITS-1:0] LINE_MASK = ~ADDR_BITS'((1 << LOW_BITS) - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state, state_nx;
   logic [1:0]           grant, grant_nx;
   logic [BEAT_BITS-1:0] beat, beat_nx;
   logic                 sd_cmd, sd_cmd_nx;
   logic                 sd_we, sd_we_nx;
   logic [ADDR_BITS-1:0] sd_addr, sd_addr_nx;
   logic [1:0]           done, done_nx;
   logic                 last, last_nx;
   logic                 pick1;
   logic                 beat_ok;

   // Beat handshake: a beat moves in any XFER cycle where the SDRAM side strobes
   // sd_rvalid (refill) or sd_wack (write-back); the cache sees it the same cycle
   // as rvalid/wnext. Strobes of the other direction or outside XFER are dropped.
   always_comb begin
      beat_ok = (state == XFER) && (sd_we ? bus.sd_wack : bus.sd_rvalid);
   end

   always_comb begin
      state_nx   = state;
      grant_nx   = grant;
      beat_nx    = beat;
      sd_cmd_nx  = sd_cmd;
      sd_we_nx   = sd_we;
      sd_addr_nx = sd_addr;
      done_nx    = 2'b00;
      last_nx    = last;
      pick1      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req != 2'b00) begin
               // on a tie, the port that did not own the previous line wins
               pick1      = (bus.req == 2'b10) || ((bus.req == 2'b11) && !last);
               grant_nx   = pick1 ? 2'b10 : 2'b01;
               sd_we_nx   = pick1 ? bus.we[1] : bus.we[0];
               sd_addr_nx = (pick1 ? bus.addr1 : bus.addr0) & LINE_MASK;
               sd_cmd_nx  = 1'b1;
               beat_nx    = '0;
               state_nx   = CMD;
            end
         end
         CMD: begin
            if (bus.sd_cmdack) begin
               sd_cmd_nx = 1'b0;
               state_nx  = XFER;
            end
         end
         XFER: begin
            if (beat_ok) begin
               beat_nx = beat + 1'b1;
               if (beat == LAST_BEAT) begin
                  state_nx = DONE;
                  done_nx  = grant;
               end
            end
         end
         DONE: begin
            last_nx  = grant[1];
            grant_nx = 2'b00;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state   <= IDLE;
         grant   <= 2'b00;
         beat    <= '0;
         sd_cmd  <= 1'b0;
         sd_we   <= 1'b0;
         sd_addr <= '0;
         done    <= 2'b00;
         last    <= 1'b1;
      end else begin
         state   <= state_nx;
         grant   <= grant_nx;
         beat    <= beat_nx;
         sd_cmd  <= sd_cmd_nx;
         sd_we   <= sd_we_nx;
         sd_addr <= sd_addr_nx;
         done    <= done_nx;
         last    <= last_nx;
      end
   end

   assign bus.grant    = grant;
   assign bus.beat     = beat;
   assign bus.done     = done;
   assign bus.sd_cmd   = sd_cmd;
   assign bus.sd_we    = sd_we;
   assign bus.sd_addr  = sd_addr;
   assign bus.rdata    = bus.sd_rdata;
   assign bus.rvalid   = ((state == XFER) && !sd_we && bus.sd_rvalid) ? grant : 2'b00;
   assign bus.wnext    = ((state == XFER) && sd_we && bus.sd_wack) ? grant : 2'b00;
   assign bus.sd_wdata = grant[1] ? bus.wdata1 : bus.wdata0;
   assign dbg_state    = state;
endmodule

// File: tb/tb_ceespu_memarbiter.sv
// Directed bench for ceespu_memarbiter: a small SDRAM/cache driver plus one
// task per scenario with hand-computed expectations.
module tb_ceespu_memarbiter;
   localparam int AB = 25;
   localparam int BL = 8;
   localparam int BB = $clog2(BL);

   logic I_clk = 1'b0;
   logic I_rst = 1'b1;
   logic [1:0] dbg_state;
   int total = 0;
   int bad = 0;

   logic [1:0]    obs_grant, obs_done, obs_grant_done, obs_done_after, obs_grant_after;
   logic          obs_we;
   logic [AB-1:0] obs_addr;
   logic [1:0]    obs_vec [BL];
   logic [31:0]   obs_data [BL];
   logic [BB-1:0] obs_beat [BL];
   logic [BB-1:0] obs_beat_done;
   int obs_lat, obs_stray, obs_cmd_bad, obs_n;

   always #5 I_clk = ~I_clk;

   ceespu_memarbiter_if #(.ADDR_BITS(AB), .BURST_LEN(BL)) bus ();

   ceespu_memarbiter #(.ADDR_BITS(AB), .BURST_LEN(BL)) dut (
      .I_clk(I_clk),
      .I_rst(I_rst),
      .bus(bus),
      .dbg_state(dbg_state)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   task automatic sample();
      @(negedge I_clk);
   endtask

   // Runs one line transfer once a request is pending: waits for the grant,
   // acks the command after ack_delay cycles, then supplies a beat every gap+1
   // cycles. Observations land in obs_*; the caller's test does the comparing.
   task automatic run_xfer(input int ack_delay, input int gap, input int drop_at,
                           input logic stray, input logic [31:0] base);
      int n;
      int p;
      int k;
      logic go;
      obs_n = 0;
      obs_stray = 0;
      obs_cmd_bad = 0;
      tick();
      n = 1;
      while (bus.grant == 2'b00 && n < 20) begin
         tick();
         n++;
      end
      obs_lat = n;
      obs_grant = bus.grant;
      obs_we = bus.sd_we;
      obs_addr = bus.sd_addr;
      p = obs_grant[1] ? 1 : 0;
      for (int d = 0; d <= ack_delay; d++) begin
         bus.sd_cmdack = (d == ack_delay);
         bus.sd_rvalid = stray;
         bus.sd_wack = stray;
         sample();
         if (bus.sd_cmd !== 1'b1 || bus.sd_addr !== obs_addr || bus.sd_we !== obs_we || bus.beat !== '0)
            obs_cmd_bad++;
         if (bus.rvalid !== 2'b00 || bus.wnext !== 2'b00) obs_stray++;
         tick();
      end
      bus.sd_cmdack = 1'b0;
      bus.sd_rvalid = 1'b0;
      bus.sd_wack = 1'b0;
      k = 0;
      while (obs_n < BL && k < 200) begin
         go = (k % (gap + 1)) == 0;
         if (drop_at >= 0 && obs_n == drop_at) bus.req[p] = 1'b0;
         if (p == 1) bus.wdata1 = base + obs_n;
         else bus.wdata0 = base + obs_n;
         bus.sd_rdata = go ? base + obs_n : $urandom;
         if (obs_we) bus.sd_wack = go;
         else bus.sd_rvalid = go;
         sample();
         if (go) begin
            obs_vec[obs_n] = obs_we ? bus.wnext : bus.rvalid;
            obs_data[obs_n] = obs_we ? bus.sd_wdata : bus.rdata;
            obs_beat[obs_n] = bus.beat;
            obs_n++;
         end else if (bus.rvalid !== 2'b00 || bus.wnext !== 2'b00) begin
            obs_stray++;
         end
         tick();
         k++;
      end
      bus.sd_wack = 1'b0;
      bus.sd_rvalid = 1'b0;
      sample();
      obs_done = bus.done;
      obs_beat_done = bus.beat;
      obs_grant_done = bus.grant;
      tick();
      bus.req[p] = 1'b0;
      sample();
      obs_done_after = bus.done;
      obs_grant_after = bus.grant;
   endtask

   task automatic test_reset();
      I_rst = 1'b1;
      tick();
      tick();
      tick();
      sample();
      total++; if (bus.grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
      total++; if (bus.beat !== '0) begin bad++; $display("FAIL reset_beat: got %0d want 0", bus.beat); end
      total++; if (bus.sd_cmd !== 1'b0 || bus.sd_we !== 1'b0) begin bad++; $display("FAIL reset_cmd_we: got %b%b want 00", bus.sd_cmd, bus.sd_we); end
      total++; if (bus.sd_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.sd_addr); end
      total++; if (bus.rvalid !== 2'b00 || bus.wnext !== 2'b00 || bus.done !== 2'b00) begin bad++; $display("FAIL reset_strobes: got rv=%b wn=%b dn=%b want 00", bus.rvalid, bus.wnext, bus.done); end
      total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      tick();
      I_rst = 1'b0;
   endtask

   task automatic test_refill();
      bus.req = 2'b01;
      bus.we = 2'b00;
      bus.addr0 = 25'h0001234;
      sample();
      total++; if (bus.grant !== 2'b00) begin bad++; $display("FAIL refill_cycle0_grant: got %b want 00", bus.grant); end
      run_xfer(0, 0, -1, 1'b0, 32'h0);
      total++; if (obs_lat !== 1 || obs_grant !== 2'b01) begin bad++; $display("FAIL refill_grant: got lat=%0d g=%b want lat=1 g=01", obs_lat, obs_grant); end
      total++; if (obs_addr !== 25'h0001220 || obs_we !== 1'b0) begin bad++; $display("FAIL refill_cmd: got addr=%h we=%b want 0001220 0", obs_addr, obs_we); end
      total++; if (obs_cmd_bad !== 0) begin bad++; $display("FAIL refill_cmd_phase: got %0d bad cycles want 0", obs_cmd_bad); end
      for (int i = 0; i < BL; i++) begin
         total++;
         if (obs_vec[i] !== 2'b01 || obs_data[i] !== 32'(i) || obs_beat[i] !== BB'(i)) begin
            bad++;
            $display("FAIL refill_beat%0d: got rv=%b d=%h b=%0d want 01 %h %0d", i, obs_vec[i], obs_data[i], obs_beat[i], i, i);
         end
      end
      total++; if (obs_done !== 2'b01 || obs_beat_done !== '0) begin bad++; $display("FAIL refill_done: got dn=%b beat=%0d want 01 0", obs_done, obs_beat_done); end
      total++; if (obs_done_after !== 2'b00 || obs_grant_after !== 2'b00) begin bad++; $display("FAIL refill_after: got dn=%b g=%b want 00 00", obs_done_after, obs_grant_after); end
   endtask

   task automatic test_alternate();
      I_rst = 1'b1;
      tick();
      tick();
      I_rst = 1'b0;
      bus.req = 2'b11;
      bus.we = 2'b00;
      bus.addr0 = 25'h0000100;
      bus.addr1 = 25'h0002000;
      run_xfer(0, 0, -1, 1'b0, 32'h100);
      total++; if (obs_grant !== 2'b01 || obs_done !== 2'b01) begin bad++; $display("FAIL alt_first: got g=%b dn=%b want 01 01", obs_grant, obs_done); end
      bus.req[0] = 1'b1;
      run_xfer(0, 0, -1, 1'b0, 32'h200);
      total++; if (obs_grant !== 2'b10 || obs_lat !== 1 || obs_addr !== 25'h0002000) begin bad++; $display("FAIL alt_second: got g=%b lat=%0d a=%h want 10 1 0002000", obs_grant, obs_lat, obs_addr); end
      total++; if (obs_done !== 2'b10 || obs_data[7] !== 32'h207) begin bad++; $display("FAIL alt_second_done: got dn=%b d7=%h want 10 207", obs_done, obs_data[7]); end
      bus.req[1] = 1'b1;
      run_xfer(0, 0, -1, 1'b0, 32'h300);
      total++; if (obs_grant !== 2'b01 || obs_lat !== 1) begin bad++; $display("FAIL alt_third: got g=%b lat=%0d want 01 1", obs_grant, obs_lat); end
      bus.req = 2'b00;
      tick();
      tick();
      sample();
      total++; if (bus.grant !== 2'b00 || dbg_state !== 2'd0) begin bad++; $display("FAIL alt_idle: got g=%b st=%0d want 00 0", bus.grant, dbg_state); end
   endtask

   task automatic test_writeback();
      tick();
      bus.req = 2'b01;
      bus.we = 2'b01;
      bus.addr0 = 25'h0ABCDEF;
      bus.wdata0 = 32'hA000_0000;
      bus.wdata1 = 32'hDEAD_BEEF;
      sample();
      run_xfer(0, 1, -1, 1'b0, 32'hA000_0000);
      total++; if (obs_we !== 1'b1 || obs_addr !== 25'h0ABCDE0 || obs_grant !== 2'b01) begin bad++; $display("FAIL wb_cmd: got we=%b a=%h g=%b want 1 0ABCDE0 01", obs_we, obs_addr, obs_grant); end
      for (int i = 0; i < BL; i++) begin
         total++;
         if (obs_vec[i] !== 2'b01 || obs_data[i] !== 32'hA000_0000 + 32'(i)) begin
            bad++;
            $display("FAIL wb_beat%0d: got wn=%b d=%h want 01 %h", i, obs_vec[i], obs_data[i], 32'hA000_0000 + 32'(i));
         end
      end
      total++; if (obs_stray !== 0) begin bad++; $display("FAIL wb_wnext_align: got %0d extra pulses want 0", obs_stray); end
      total++; if (obs_done !== 2'b01 || obs_done_after !== 2'b00) begin bad++; $display("FAIL wb_done: got %b then %b want 01 then 00", obs_done, obs_done_after); end
      bus.we = 2'b00;
   endtask

   task automatic test_cmd_delay();
      int leak;
      leak = 0;
      tick();
      bus.sd_rvalid = 1'b1;
      bus.sd_wack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         if (bus.rvalid !== 2'b00 || bus.wnext !== 2'b00 || bus.beat !== '0 || bus.grant !== 2'b00) leak++;
         tick();
      end
      total++; if (leak !== 0) begin bad++; $display("FAIL idle_stray: got %0d leaking cycles want 0", leak); end
      bus.sd_rvalid = 1'b0;
      bus.sd_wack = 1'b0;
      bus.req = 2'b01;
      bus.we = 2'b00;
      bus.addr0 = 25'h1FFFFFF;
      sample();
      run_xfer(5, 0, -1, 1'b1, 32'h55);
      total++; if (obs_addr !== 25'h1FFFFE0 || obs_lat !== 1) begin bad++; $display("FAIL delay_addr: got a=%h lat=%0d want 1FFFFE0 1", obs_addr, obs_lat); end
      total++; if (obs_cmd_bad !== 0) begin bad++; $display("FAIL delay_cmd_hold: got %0d bad cycles want 0", obs_cmd_bad); end
      total++; if (obs_stray !== 0) begin bad++; $display("FAIL delay_stray: got %0d forwarded want 0", obs_stray); end
      total++; if (obs_beat[0] !== '0 || obs_data[0] !== 32'h55 || obs_data[7] !== 32'h5C) begin bad++; $display("FAIL delay_beats: got b0=%0d d0=%h d7=%h want 0 55 5c", obs_beat[0], obs_data[0], obs_data[7]); end
      total++; if (obs_done !== 2'b01) begin bad++; $display("FAIL delay_done: got %b want 01", obs_done); end
   endtask

   task automatic test_reset_mid();
      tick();
      bus.req = 2'b01;
      bus.we = 2'b00;
      bus.addr0 = 25'h0000040;
      tick();
      bus.sd_cmdack = 1'b1;
      tick();
      bus.sd_cmdack = 1'b0;
      for (int b = 0; b < 4; b++) begin
         bus.sd_rvalid = 1'b1;
         bus.sd_rdata = 32'(b);
         tick();
      end
      bus.sd_rvalid = 1'b1;
      I_rst = 1'b1;
      sample();
      total++; if (bus.beat !== BB'(4) || bus.rvalid !== 2'b01) begin bad++; $display("FAIL rstmid_pre: got beat=%0d rv=%b want 4 01", bus.beat, bus.rvalid); end
      tick();
      I_rst = 1'b0;
      bus.req = 2'b00;
      sample();
      total++; if (bus.grant !== 2'b00 || bus.beat !== '0 || bus.sd_cmd !== 1'b0 || bus.sd_addr !== '0) begin bad++; $display("FAIL rstmid_regs: got g=%b b=%0d cmd=%b a=%h want 00 0 0 0", bus.grant, bus.beat, bus.sd_cmd, bus.sd_addr); end
      total++; if (bus.rvalid !== 2'b00 || bus.done !== 2'b00 || dbg_state !== 2'd0) begin bad++; $display("FAIL rstmid_out: got rv=%b dn=%b st=%0d want 00 00 0", bus.rvalid, bus.done, dbg_state); end
      bus.sd_rvalid = 1'b0;
      bus.req = 2'b10;
      bus.addr1 = 25'h0000300;
      run_xfer(0, 0, -1, 1'b0, 32'h300);
      total++; if (obs_grant !== 2'b10 || obs_lat !== 1 || obs_addr !== 25'h0000300) begin bad++; $display("FAIL rstmid_new_grant: got g=%b lat=%0d a=%h want 10 1 0000300", obs_grant, obs_lat, obs_addr); end
      total++; if (obs_vec[0] !== 2'b10 || obs_vec[7] !== 2'b10 || obs_beat[7] !== BB'(7)) begin bad++; $display("FAIL rstmid_new_beats: got v0=%b v7=%b b7=%0d want 10 10 7", obs_vec[0], obs_vec[7], obs_beat[7]); end
      total++; if (obs_done !== 2'b10) begin bad++; $display("FAIL rstmid_new_done: got %b want 10", obs_done); end
   endtask

   task automatic test_drop_req();
      tick();
      bus.req = 2'b01;
      bus.we = 2'b00;
      bus.addr0 = 25'h0000080;
      sample();
      run_xfer(0, 0, 2, 1'b0, 32'h700);
      total++; if (obs_vec[2] !== 2'b01 || obs_vec[7] !== 2'b01 || obs_data[7] !== 32'h707) begin bad++; $display("FAIL drop_beats: got v2=%b v7=%b d7=%h want 01 01 707", obs_vec[2], obs_vec[7], obs_data[7]); end
      total++; if (obs_done !== 2'b01 || obs_grant_done !== 2'b01) begin bad++; $display("FAIL drop_done: got dn=%b g=%b want 01 01", obs_done, obs_grant_done); end
      tick();
      sample();
      total++; if (bus.grant !== 2'b00) begin bad++; $display("FAIL drop_no_regrant: got %b want 00", bus.grant); end
   endtask

   initial begin
      bus.req = 2'b00;
      bus.we = 2'b00;
      bus.addr0 = '0;
      bus.addr1 = '0;
      bus.wdata0 = '0;
      bus.wdata1 = '0;
      bus.sd_cmdack = 1'b0;
      bus.sd_wack = 1'b0;
      bus.sd_rdata = '0;
      bus.sd_rvalid = 1'b0;
      test_reset();
      test_refill();
      test_alternate();
      test_writeback();
      test_cmd_delay();
      test_reset_mid();
      test_drop_req();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
